// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB3 timer peripheral, 32-bit down-counter with prescaler, external tick and level IRQ.
// Optional define APB_TIMER_PSLVERR_EN flags unmapped accesses and VALUE writes with PSLVERR.
module apb_timer_slave #(
    parameter int ADDRWIDTH   = 12,
    parameter int DATAWIDTH   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    input  logic                 EXTIN,
    output logic                 TIMERINT
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state, state_nx;
    logic [3:0]  wcnt;
    logic [3:0]  ctrl;
    logic [31:0] load, value, rdata;
    logic [7:0]  prescale, psc_cnt;
    logic        intstat, sync1, sync2, sync3;
    logic [2:0]  sel;
    logic        access, err, wr, tick, tick_ok, expire;
    logic        unused_paddr;

    assign unused_paddr = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0]};
    assign sel          = PADDR[4:2];
    assign access       = state == DONE && PSEL && PENABLE;
`ifdef APB_TIMER_PSLVERR_EN
    assign err = sel > 3'd4 || (PWRITE && sel == 3'd2);
`else
    assign err = 1'b0;
`endif
    assign wr      = access && PWRITE && !err;
    assign PREADY  = state == DONE;
    assign PSLVERR = access && err;
    assign PRDATA  = (access && !PWRITE) ? rdata : '0;

    // A CTRL write clearing EN discards a tick landing on the same edge
    assign tick    = ctrl[0] && (ctrl[3] ? (sync2 && !sync3) : (psc_cnt == prescale));
    assign tick_ok = tick && !(wr && sel == 3'd0 && !PWDATA[0]);
    assign expire  = tick_ok && value <= 32'd1;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (PSEL && !PENABLE) state_nx = WAIT_STATES > 0 ? WAIT : DONE;
            WAIT:    if (wcnt == 4'(WAIT_STATES - 1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (sel)
            3'd0:    rdata = {28'd0, ctrl};
            3'd1:    rdata = load;
            3'd2:    rdata = value;
            3'd3:    rdata = {24'd0, prescale};
            3'd4:    rdata = {31'd0, intstat};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            wcnt     <= '0;
            ctrl     <= '0;
            load     <= '0;
            value    <= '0;
            prescale <= '0;
            psc_cnt  <= '0;
            intstat  <= 1'b0;
            {sync3, sync2, sync1} <= '0;
            TIMERINT <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= state == WAIT ? wcnt + 4'd1 : 4'd0;
            {sync3, sync2, sync1} <= {sync2, sync1, EXTIN};
            psc_cnt <= (!ctrl[0] || ctrl[3] || psc_cnt == prescale) ? 8'd0 : psc_cnt + 8'd1;
            if (wr && sel == 3'd0)
                ctrl <= PWDATA[3:0];
            else if (expire && ctrl[2])
                ctrl[0] <= 1'b0;
            if (wr && sel == 3'd1)
                load <= PWDATA;
            if (wr && sel == 3'd1)
                value <= PWDATA;
            else if (expire)
                value <= ctrl[2] ? 32'd0 : load;
            else if (tick_ok)
                value <= value - 32'd1;
            if (wr && sel == 3'd3)
                prescale <= PWDATA[7:0];
            if (expire)
                intstat <= 1'b1;
            else if (wr && sel == 3'd4 && PWDATA[0])
                intstat <= 1'b0;
            TIMERINT <= intstat && ctrl[1];
        end
    end
endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: directed bench for apb_timer_slave (zero-wait and 2-wait-state instances).
module tb_apb_timer_slave;
    logic        PCLK = 0, PRESET = 1;
    logic        psel0 = 0, psel2 = 0, penable = 0, pwrite = 0, ext = 0, ext2 = 0;
    logic [11:0] paddr = 0;
    logic [31:0] pwdata = 0;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2, tint0, tint2;
    int          checks = 0, errors = 0, cyc = 0, rises = 0, ti_rise = -1;
    logic        ti_last = 0;
`ifdef APB_TIMER_PSLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    apb_timer_slave #(.ADDRWIDTH(12), .DATAWIDTH(32), .WAIT_STATES(0)) u0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .EXTIN(ext), .TIMERINT(tint0));
    apb_timer_slave #(.ADDRWIDTH(12), .DATAWIDTH(32), .WAIT_STATES(2)) u2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel2), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2),
        .PSLVERR(pslverr2), .EXTIN(ext2), .TIMERINT(tint2));

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) begin
        if (tint0 && !ti_last) begin
            rises++;
            if (ti_rise < 0) ti_rise = cyc;
        end
        ti_last = tint0;
    end

    // Called just after a rising edge; setup phase starts immediately, write commits on the edge ending DONE
    task automatic apb(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int nw, output logic er, output logic rs);
        if (d == 0) psel0 = 1; else psel2 = 1;
        penable = 0; paddr = a; pwrite = wr; pwdata = wd; nw = 0;
        @(negedge PCLK);
        rs = (d == 0) ? pready0 : pready2;
        @(posedge PCLK); #1;
        penable = 1;
        @(negedge PCLK);
        while (!((d == 0) ? pready0 : pready2) && nw < 20) begin
            nw++;
            @(negedge PCLK);
        end
        if (nw >= 20) begin
            errors++;
            $display("FAIL apb_timeout addr %0h waited %0d cycles, PREADY never rose", a, nw);
        end
        rd = (d == 0) ? prdata0 : prdata2;
        er = (d == 0) ? pslverr0 : pslverr2;
        @(posedge PCLK); #1;
        psel0 = 0; psel2 = 0; penable = 0;
    endtask

    task automatic rd0(input logic [11:0] a, output logic [31:0] d);
        int n; logic e, s;
        apb(0, 0, a, 32'd0, d, n, e, s);
    endtask

    task automatic wr0(input logic [11:0] a, input logic [31:0] v);
        int n; logic e, s; logic [31:0] d;
        apb(0, 1, a, v, d, n, e, s);
    endtask

    task automatic pulse();
        ext = 1;
        repeat (3) @(posedge PCLK);
        #1 ext = 0;
        repeat (3) @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; int n; logic e, s;
        @(negedge PCLK);
        checks++; if ({pready0, pslverr0, tint0, pready2} !== 4'b0) begin errors++; $display("FAIL rst_outs got %b exp 0000", {pready0, pslverr0, tint0, pready2}); end
        checks++; if (prdata0 !== 32'd0) begin errors++; $display("FAIL rst_prdata got %h exp 0", prdata0); end
        @(posedge PCLK); #1 PRESET = 0;
        for (int i = 0; i < 8; i++) begin
            apb(0, 0, 12'(i * 4), 32'd0, d, n, e, s);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_read%0d got %h exp 0", i, d); end
            checks++; if (n !== 0 || s !== 1'b0) begin errors++; $display("FAIL rst_ready%0d got waits %0d setup_ready %b exp 0 0", i, n, s); end
        end
        checks++; if (tint0 !== 1'b0) begin errors++; $display("FAIL rst_tint got %b exp 0", tint0); end
    endtask

    task automatic test_wait_states();
        logic [31:0] d; int n; logic e, s;
        apb(2, 1, 12'h004, 32'd5, d, n, e, s);
        checks++; if (n !== 2 || s !== 1'b0) begin errors++; $display("FAIL ws_write got waits %0d setup_ready %b exp 2 0", n, s); end
        apb(2, 0, 12'h008, 32'd0, d, n, e, s);
        checks++; if (d !== 32'd5 || n !== 2) begin errors++; $display("FAIL ws_read got %h waits %0d exp 5 waits 2", d, n); end
    endtask

    task automatic test_periodic();
        logic [31:0] d; int c0;
        wr0(12'h004, 32'd3); wr0(12'h00C, 32'd1);
        ti_rise = -1;
        wr0(12'h000, 32'h3);
        c0 = cyc;
        rd0(12'h008, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL per_v1 got %h exp 3", d); end
        rd0(12'h008, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL per_v3 got %h exp 2", d); end
        rd0(12'h010, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL per_int5 got %h exp 0", d); end
        rd0(12'h008, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL per_reload got %h exp 3", d); end
        rd0(12'h010, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL per_int9 got %h exp 1", d); end
        checks++; if (ti_rise - c0 !== 7) begin errors++; $display("FAIL per_tint_lat got %0d exp 7", ti_rise - c0); end
        wr0(12'h000, 32'h2);
        wr0(12'h010, 32'h1);
        @(posedge PCLK); @(negedge PCLK);
        checks++; if (tint0 !== 1'b0) begin errors++; $display("FAIL per_w1c got %b exp 0", tint0); end
        @(posedge PCLK); #1;
    endtask

    task automatic test_oneshot();
        logic [31:0] d; int c0;
        wr0(12'h00C, 32'd0); wr0(12'h004, 32'd2);
        rises = 0; ti_rise = -1;
        wr0(12'h000, 32'h7);
        c0 = cyc;
        rd0(12'h000, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL os_ctrl1 got %h exp 7", d); end
        rd0(12'h000, d);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL os_en_clr got %h exp 6", d); end
        rd0(12'h008, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_value got %h exp 0", d); end
        rd0(12'h010, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL os_int got %h exp 1", d); end
        checks++; if (ti_rise - c0 !== 3) begin errors++; $display("FAIL os_tint_lat got %0d exp 3", ti_rise - c0); end
        wr0(12'h010, 32'h1);
        repeat (10) @(posedge PCLK);
        #1;
        rd0(12'h010, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_no_reint got %h exp 0", d); end
        rd0(12'h008, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_hold got %h exp 0", d); end
        checks++; if (rises !== 1) begin errors++; $display("FAIL os_irq_count got %0d exp 1", rises); end
    endtask

    task automatic test_extin();
        logic [31:0] d; int c0;
        wr0(12'h000, 32'hA); wr0(12'h004, 32'd4);
        pulse(); pulse();
        rd0(12'h008, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL ext_en0 got %h exp 4", d); end
        wr0(12'h000, 32'hB);
        ti_rise = -1;
        pulse(); pulse(); pulse();
        rd0(12'h008, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL ext_count3 got %h exp 1", d); end
        c0 = cyc;
        pulse();
        checks++; if (ti_rise - c0 !== 4) begin errors++; $display("FAIL ext_lat got %0d exp 4", ti_rise - c0); end
        rd0(12'h008, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL ext_reload got %h exp 4", d); end
        wr0(12'h000, 32'h0); wr0(12'h010, 32'h1);
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        wr0(12'h00C, 32'd0); wr0(12'h004, 32'd50); wr0(12'h000, 32'h1);
        wr0(12'h004, 32'd100);
        rd0(12'h008, d);
        checks++; if (d !== 32'd99) begin errors++; $display("FAIL sim_load_wins got %0d exp 99", d); end
        wr0(12'h000, 32'h0);
        rd0(12'h008, d);
        checks++; if (d !== 32'd97) begin errors++; $display("FAIL sim_tick_drop got %0d exp 97", d); end
        wr0(12'h004, 32'd1); wr0(12'h000, 32'h3);
        wr0(12'h010, 32'h1);
        @(posedge PCLK); @(negedge PCLK);
        checks++; if (tint0 !== 1'b1) begin errors++; $display("FAIL sim_set_wins got %b exp 1", tint0); end
        @(posedge PCLK); #1;
        wr0(12'h000, 32'h0); wr0(12'h010, 32'h1);
        rd0(12'h010, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL sim_clear got %h exp 0", d); end
    endtask

    task automatic test_pslverr();
        logic [31:0] d; int n; logic e, s;
        wr0(12'h004, 32'h55);
        apb(0, 0, 12'h014, 32'd0, d, n, e, s);
        checks++; if (e !== EXP_ERR || d !== 32'd0) begin errors++; $display("FAIL err_unmapped got err %b data %h exp %b 0", e, d, EXP_ERR); end
        apb(0, 1, 12'h008, 32'hDEAD, d, n, e, s);
        checks++; if (e !== EXP_ERR) begin errors++; $display("FAIL err_wr_value got %b exp %b", e, EXP_ERR); end
        rd0(12'h008, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL err_value_kept got %h exp 55", d); end
        apb(0, 1, 12'h018, 32'hF, d, n, e, s);
        rd0(12'h000, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_ctrl_kept got %h exp 0", d); end
        apb(0, 0, 12'h104, 32'd0, d, n, e, s);
        checks++; if (d !== 32'h55 || e !== 1'b0) begin errors++; $display("FAIL alias_load got %h err %b exp 55 0", d, e); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        wr0(12'h004, 32'd1); wr0(12'h000, 32'h3);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        checks++; if (tint0 !== 1'b1) begin errors++; $display("FAIL ar_pre got %b exp 1", tint0); end
        #2 PRESET = 1;
        #1;
        checks++; if (tint0 !== 1'b0) begin errors++; $display("FAIL ar_async got %b exp 0", tint0); end
        @(posedge PCLK); #1 PRESET = 0;
        rd0(12'h000, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ar_ctrl got %h exp 0", d); end
        rd0(12'h004, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ar_load got %h exp 0", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wait_states();
        test_periodic();
        test_oneshot();
        test_extin();
        test_simultaneous();
        test_pslverr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB3 slave peripheral on the downstream side of the AHB-to-APB bridge; it consumes the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA/PREADY/PSLVERR.
- Contains a 32-bit down-counting timer with an 8-bit prescaler, an optional external tick source, periodic or one-shot modes, and a level interrupt.
- Serves as the first real APB target behind the bridge and as its verification load.

Parameters:
- ADDRWIDTH, 12: PADDR width; decode uses PADDR[4:2], upper bits ignored.
- DATAWIDTH, 32: APB data width; fixed at 32.
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase (0..15).

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  ADDRWIDTH  byte address, word aligned.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATAWIDTH  write data.
- PRDATA  out  DATAWIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response.
- EXTIN  in  1  asynchronous external tick input.
- TIMERINT  out  1  interrupt, level, active-high.

Behaviour:
- Single clock PCLK; PRESET asynchronous active-high. Every register and output clears to 0 on reset, including PRDATA, PREADY, PSLVERR, TIMERINT, the counters and the synchronisers. Reset asserted mid-transfer or mid-count aborts it immediately.
- Register map (offset, access):
  - 0x00 CTRL, RW: [0] EN, [1] IRQEN, [2] ONESHOT, [3] EXTSEL; other bits read 0.
  - 0x04 LOAD, RW: a write also copies the value into VALUE.
  - 0x08 VALUE, RO.
  - 0x0C PRESCALE, RW, [7:0].
  - 0x10 INTSTAT, read [0] / write-1-to-clear.
  - 0x14-0x1C unmapped; read 0, writes ignored.
- APB handshake:
  - Setup phase is PSEL & !PENABLE.
  - An access-phase state machine has states IDLE, WAIT and DONE:
    - IDLE->WAIT on a setup phase when WAIT_STATES > 0; IDLE->DONE on a setup phase when WAIT_STATES = 0.
    - WAIT counts WAIT_STATES cycles, then goes to DONE.
    - DONE drives PREADY = 1 for exactly one cycle (the cycle in which PSEL & PENABLE are high), then returns to IDLE.
  - Zero-wait transfers take 2 PCLK cycles; with wait states they take 2 + WAIT_STATES cycles.
  - PREADY is low outside DONE.
- Write commit: registers update on the edge ending the DONE cycle with PWRITE = 1. Writes to VALUE have no effect.
- Read data: PRDATA is valid in the DONE cycle of a read and is 0 at all other times.
- Tick generation:
  - EXTSEL = 0: the prescaler counts 0..PRESCALE while EN = 1 and issues a tick when it equals PRESCALE, then returns to 0. PRESCALE = 0 gives a tick every cycle. The prescaler is held at 0 while EN = 0.
  - EXTSEL = 1: EXTIN passes through a 2-flop synchroniser and a rising-edge detector; each detected edge is a tick when EN = 1. The prescaler is bypassed. EXTIN-to-tick latency is 3 cycles.
- Count on a tick:
  - VALUE > 1: VALUE decrements by 1.
  - VALUE <= 1: INTSTAT is set. If ONESHOT = 0, VALUE reloads from LOAD. If ONESHOT = 1, VALUE goes to 0 and EN clears.
  - Period is therefore LOAD ticks; LOAD = 0 or 1 interrupts on every tick.
- TIMERINT = INTSTAT & IRQEN, registered, so it follows INTSTAT by 1 cycle.
- Simultaneous events:
  - A LOAD write in the same cycle as a tick: the write wins, VALUE = new LOAD.
  - An INTSTAT clear in the same cycle as a set: the set wins.
  - A CTRL write clearing EN in the same cycle as a tick: the tick is discarded.
- Arithmetic is unsigned 32-bit; VALUE never wraps below 0.

Optional Feature:
- Macro: APB_TIMER_PSLVERR_EN.
- Defined: PSLVERR = 1 in the DONE cycle of any access to an unmapped offset and of any write to VALUE; the register state is unchanged in those cases.
- Undefined: PSLVERR is tied to 0 and those accesses complete silently.

Test Plan:
- Reset then idle: read all offsets -> all read 0x0; PREADY high only in the access-phase cycle; TIMERINT = 0.
- WAIT_STATES = 2: write LOAD = 0x5 -> PREADY low for 2 access cycles, then high for 1; read VALUE = 0x5.
- LOAD = 3, PRESCALE = 1, CTRL = 0x3 -> VALUE steps 3,2,1 every 2 cycles; INTSTAT = 1 after 6 cycles; TIMERINT one cycle later; VALUE reloads to 3; write INTSTAT = 1 -> TIMERINT drops.
- ONESHOT: LOAD = 2, PRESCALE = 0, CTRL = 0x7 -> VALUE reaches 0, EN reads 0, VALUE holds 0, exactly one interrupt.
- EXTSEL: CTRL = 0x9, LOAD = 4, 4 EXTIN pulses each 3 cycles wide -> INTSTAT = 1 three cycles after the 4th rising edge; pulses with EN = 0 are ignored.
- With APB_TIMER_PSLVERR_EN: read 0x14 and write VALUE -> PSLVERR = 1 in DONE and VALUE unchanged; without the macro -> PSLVERR = 0.
